flash_cmd_sequencer: RTL and testbench
======================================

Name: flash_cmd_sequencer

Overview:
- Guards and sequences CPU writes to the PRG flash in $8000-$FFFF.
- Passes the write strobe only for well-formed JEDEC command sequences: unlock, program, sector/chip erase, autoselect, reset.
- Tracks program/erase busy time and blocks writes while busy.
- Sits between the CPU bus decode and the flash_we gating; write_allow replaces the raw prg_write_enabled term.

Parameters:
- TIMEOUT_CYCLES, 64: m2 cycles a partial sequence may idle before abort.
- PROG_CYCLES, 16: m2 cycles of busy after a program data write.
- ERASE_CYCLES, 1800000: m2 cycles of busy after an erase confirm.
- BUSY_W, 22: busy counter width; must hold ERASE_CYCLES.

Ports:
- m2  in  1  CPU M2, sole clock; state updates on falling edge.
- reset  in  1  asynchronous, active-high.
- romsel  in  1  low = $8000-$FFFF access.
- cpu_rw_in  in  1  low = write.
- cpu_addr_in  in  15  CPU A14..A0.
- cpu_data_in  in  8  CPU data bus.
- prg_write_enabled  in  1  mapper permission for flash writes.
- write_allow  out  1  combinational permit for the current write strobe.
- flash_busy  out  1  high while the busy timer runs.
- abort_pulse  out  1  one-cycle pulse when a sequence is aborted.
- seq_state  out  3  current FSM state, for debug.

Behaviour:
- Interface: one clock, m2. Reset is asynchronous and active-high.
- Write cycle: romsel==0 and cpu_rw_in==0. Sampled at the m2 falling edge that ends the cycle.
- Command address: cpu_addr_in[10:0] only. CA1=$555, CA2=$2AA.
- FSM states: IDLE=0, U1=1, U2=2, PROG=3, E1=4, E2=5, E3=6, BUSY=7. Reset goes to IDLE.
- Reset values: flash_busy=0, abort_pulse=0, seq_state=0, counters=0.
- write_allow is forced 0 while reset is high.
- write_allow=1 only for an expected write, and only when prg_write_enabled==1 and state!=BUSY. Otherwise 0.
- Expected writes and transitions:
  - IDLE: $AA@CA1 -> U1. $F0 at any address -> IDLE.
  - U1: $55@CA2 -> U2.
  - U2, all to CA1: $A0 -> PROG; $80 -> E1; $90 -> IDLE (autoselect); $F0 -> IDLE.
  - PROG: any address/data -> BUSY, load PROG_CYCLES.
  - E1: $AA@CA1 -> E2.
  - E2: $55@CA2 -> E3.
  - E3: $10@CA1 (chip erase) or $30 at any address (sector erase) -> BUSY, load ERASE_CYCLES.
- $F0 in any non-BUSY state: allowed, goes to IDLE.
- Unexpected write in U1..E3: blocked, go to IDLE, abort_pulse=1 next cycle.
- Unexpected write in IDLE: blocked, no pulse.
- Timeout: in U1..E3, an idle counter counts m2 cycles without a write. It clears on every accepted write. At TIMEOUT_CYCLES: go to IDLE, abort_pulse=1.
- Non-ROM and read cycles do not change state; they only advance counters.
- BUSY: all writes blocked. Counter decrements each cycle; flash_busy=1 throughout. At 0 -> IDLE, and flash_busy drops the same edge.
- Busy length: exactly PROG_CYCLES or ERASE_CYCLES falling edges after the loading edge.
- prg_write_enabled low in U1..E3: next edge forces IDLE with abort_pulse=1.
- prg_write_enabled low in BUSY: no effect; flash is physically busy.
- A write coinciding with the timeout edge is evaluated first. If accepted, the timeout is cancelled.
- reset mid-BUSY: immediate IDLE, flash_busy=0. Firmware must poll the flash itself.

Decomposition:
- Shared package holds:
  - state encodings;
  - CA1/CA2 and command bytes $AA $55 $A0 $80 $90 $F0 $10 $30.
- One sub-module, flash_busy_timer: loadable BUSY_W down-counter with a done flag.
- Sequence FSM and timeout counter stay in the top module.

Test Plan:
- Program: writes $AA@$8555, $55@$82AA, $A0@$8555, $3C@$9123 with prg_write_enabled=1 -> write_allow=1 on all four. flash_busy=1 for 16 cycles, then IDLE; writes during busy see write_allow=0.
- Chip erase: six-write sequence ending $10@$8555 -> all allowed. flash_busy high for ERASE_CYCLES (bench overrides it to 100); seq_state=7, then 0.
- Bad unlock: $AA@$8555, then $56@$82AA -> second write_allow=0. abort_pulse=1 for one cycle; seq_state=0.
- Timeout: $AA@$8555, then 64 read cycles -> abort_pulse at the 64th. A following $55@$82AA is blocked.
- Permission: prg_write_enabled=0, full program sequence -> write_allow=0 throughout, state stays IDLE. Dropping enable in U2 gives abort_pulse and IDLE.
- Reset mid-erase: assert reset during BUSY -> flash_busy=0 and seq_state=0 immediately. $F0@$8000 is then allowed.

Source files
------------

// File: rtl/flash_cmd_sequencer_pkg.sv
// Shared encodings for the PRG flash command sequencer: FSM states, command addresses, command bytes.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package flash_cmd_sequencer_pkg;

  // Sequence FSM states; the numeric values are visible on seq_state for debug.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_U1   = 3'd1,
    ST_U2   = 3'd2,
    ST_PROG = 3'd3,
    ST_E1   = 3'd4,
    ST_E2   = 3'd5,
    ST_E3   = 3'd6,
    ST_BUSY = 3'd7
  } seq_state_t;

  // Command addresses decode only A10..A0, so they alias across the whole ROM window.
  localparam logic [10:0] CA1 = 11'h555;
  localparam logic [10:0] CA2 = 11'h2AA;

  // JEDEC command bytes.
  localparam logic [7:0] CMD_UNLOCK1      = 8'hAA;
  localparam logic [7:0] CMD_UNLOCK2      = 8'h55;
  localparam logic [7:0] CMD_PROGRAM      = 8'hA0;
  localparam logic [7:0] CMD_ERASE        = 8'h80;
  localparam logic [7:0] CMD_AUTOSEL      = 8'h90;
  localparam logic [7:0] CMD_RESET        = 8'hF0;
  localparam logic [7:0] CMD_CHIP_ERASE   = 8'h10;
  localparam logic [7:0] CMD_SECTOR_ERASE = 8'h30;

endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// CPU-side write bus into the flash command sequencer plus its status outputs.
// Latency: none (wiring only).
// Backpressure: none; the sequencer answers with a combinational write permit.
interface flash_cmd_sequencer_if;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        prg_write_enabled;
  logic        write_allow;
  logic        flash_busy;
  logic        abort_pulse;
  logic [2:0]  seq_state;

  // Bus side: drives the CPU cycle, observes the permit and status.
  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, prg_write_enabled,
    input  write_allow, flash_busy, abort_pulse, seq_state
  );

  // Sequencer side.
  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, prg_write_enabled,
    output write_allow, flash_busy, abort_pulse, seq_state
  );
endinterface

// File: rtl/flash_busy_timer.sv
// Loadable down-counter that models flash program/erase busy time.
// Latency: counter loads on the falling m2 edge of i_load, then counts down one per falling edge.
// Backpressure: none; o_done flags the edge on which the count reaches zero.
module flash_busy_timer #(
  parameter int BUSY_W = 22
) (
  input  logic              m2,
  input  logic              reset,
  input  logic              i_load,
  input  logic [BUSY_W-1:0] i_load_val,
  output logic              o_busy,
  output logic              o_done
);

  logic [BUSY_W-1:0] r_cnt;

  // Load wins over counting; the counter parks at zero once expired.
  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - BUSY_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  // True during the last busy cycle: the coming edge takes the count to zero.
  assign o_done = (r_cnt == BUSY_W'(1));

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Guards CPU writes to PRG flash, passing only well-formed JEDEC command sequences.
// Latency: write_allow is combinational; state, abort_pulse and flash_busy update on falling m2.
// Backpressure: writes are blocked (write_allow=0) while busy, unpermitted or out of sequence.
module flash_cmd_sequencer
  import flash_cmd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PROG_CYCLES    = 16,
  parameter int ERASE_CYCLES   = 1800000,
  parameter int BUSY_W         = 22
) (
  input  logic                        m2,
  input  logic                        reset,
  flash_cmd_sequencer_if.slave        bus
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  seq_state_t        w_target;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic              r_abort;
  logic              w_abort_nxt;
  logic              w_write;
  logic              w_expected;
  logic              w_accept;
  logic              w_load_req;
  logic              w_load;
  logic [BUSY_W-1:0] w_load_val;
  logic              w_timer_busy;
  logic              w_timer_done;
  logic [10:0]       w_cmd_addr;
  logic [7:0]        w_data;
  logic              w_unused_addr;

  assign w_write    = ~bus.romsel & ~bus.cpu_rw_in;
  assign w_cmd_addr = bus.cpu_addr_in[10:0];
  assign w_data     = bus.cpu_data_in;
  // Upper address bits play no part in command decode.
  assign w_unused_addr = ^bus.cpu_addr_in[14:11];

  // Decide which write the current state is waiting for and where it leads.
  always_comb begin
    w_expected = 1'b0;
    w_target   = ST_IDLE;
    w_load_req = 1'b0;
    w_load_val = '0;
    if (r_state != ST_BUSY && w_data == CMD_RESET) begin
      // Reset command is legal anywhere outside BUSY and returns to IDLE.
      w_expected = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_addr == CA1 && w_data == CMD_UNLOCK1) begin
            w_expected = 1'b1;
            w_target   = ST_U1;
          end
        end
        ST_U1: begin
          if (w_cmd_addr == CA2 && w_data == CMD_UNLOCK2) begin
            w_expected = 1'b1;
            w_target   = ST_U2;
          end
        end
        ST_U2: begin
          if (w_cmd_addr == CA1) begin
            case (w_data)
              CMD_PROGRAM: begin
                w_expected = 1'b1;
                w_target   = ST_PROG;
              end
              CMD_ERASE: begin
                w_expected = 1'b1;
                w_target   = ST_E1;
              end
              CMD_AUTOSEL: begin
                // Autoselect is let through but not tracked further.
                w_expected = 1'b1;
                w_target   = ST_IDLE;
              end
              default: ;
            endcase
          end
        end
        ST_PROG: begin
          // The program data write itself: any address, any byte.
          w_expected = 1'b1;
          w_target   = ST_BUSY;
          w_load_req = 1'b1;
          w_load_val = BUSY_W'(PROG_CYCLES);
        end
        ST_E1: begin
          if (w_cmd_addr == CA1 && w_data == CMD_UNLOCK1) begin
            w_expected = 1'b1;
            w_target   = ST_E2;
          end
        end
        ST_E2: begin
          if (w_cmd_addr == CA2 && w_data == CMD_UNLOCK2) begin
            w_expected = 1'b1;
            w_target   = ST_E3;
          end
        end
        ST_E3: begin
          if ((w_cmd_addr == CA1 && w_data == CMD_CHIP_ERASE) || w_data == CMD_SECTOR_ERASE) begin
            w_expected = 1'b1;
            w_target   = ST_BUSY;
            w_load_req = 1'b1;
            w_load_val = BUSY_W'(ERASE_CYCLES);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_accept = w_write & w_expected & bus.prg_write_enabled & (r_state != ST_BUSY);
  assign w_load   = w_accept & w_load_req;

  // Next state, idle-timeout count and abort request for the coming falling edge.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_abort_nxt = 1'b0;
    if (r_state == ST_BUSY) begin
      // Flash is physically busy: permission changes and writes are ignored.
      w_idle_nxt = '0;
      if (w_timer_done || !w_timer_busy) begin
        w_state_nxt = ST_IDLE;
      end
    end else if (r_state == ST_IDLE) begin
      // Stray writes in IDLE are simply dropped, without an abort.
      w_idle_nxt = '0;
      if (w_accept) begin
        w_state_nxt = w_target;
      end
    end else if (!bus.prg_write_enabled) begin
      w_state_nxt = ST_IDLE;
      w_idle_nxt  = '0;
      w_abort_nxt = 1'b1;
    end else if (w_write) begin
      // A write is judged before the timeout, so an accepted write cancels it.
      w_idle_nxt = '0;
      if (w_accept) begin
        w_state_nxt = w_target;
      end else begin
        w_state_nxt = ST_IDLE;
        w_abort_nxt = 1'b1;
      end
    end else if (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      w_state_nxt = ST_IDLE;
      w_idle_nxt  = '0;
      w_abort_nxt = 1'b1;
    end else begin
      w_idle_nxt = r_idle_cnt + IDLE_W'(1);
    end
  end

  // State, timeout counter and abort pulse registers, all on falling m2.
  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  flash_busy_timer #(
    .BUSY_W (BUSY_W)
  ) u_busy_timer (
    .m2         (m2),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_busy     (w_timer_busy),
    .o_done     (w_timer_done)
  );

  assign bus.write_allow = w_accept & ~reset;
  assign bus.flash_busy  = w_timer_busy;
  assign bus.abort_pulse = r_abort;
  assign bus.seq_state   = r_state;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer with a sequence-table reference model.
// Latency: model tracks the falling-edge state; outputs are compared on every rising m2 edge.
// Backpressure: n/a (bench).
module tb_flash_cmd_sequencer;

  localparam int TMO   = 64;
  localparam int PROG  = 16;
  localparam int ERASE = 100;

  logic m2;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  flash_cmd_sequencer_if bus_if ();

  flash_cmd_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .PROG_CYCLES    (PROG),
    .ERASE_CYCLES   (ERASE),
    .BUSY_W         (22)
  ) dut (
    .m2    (m2),
    .reset (rst),
    .bus   (bus_if)
  );

  initial begin
    m2 = 1'b1;
    forever #5 m2 = ~m2;
  end

  // Legal command sequences as (address, data) steps; -1 means "any".
  int seq_a [4][6] = '{'{'h555, 'h2AA, 'h555,   -1,     0,     0},
                       '{'h555, 'h2AA, 'h555, 'h555, 'h2AA, 'h555},
                       '{'h555, 'h2AA, 'h555, 'h555, 'h2AA,    -1},
                       '{'h555, 'h2AA, 'h555,    0,     0,     0}};
  int seq_d [4][6] = '{'{'hAA, 'h55, 'hA0,  -1,    0,    0},
                       '{'hAA, 'h55, 'h80, 'hAA, 'h55, 'h10},
                       '{'hAA, 'h55, 'h80, 'hAA, 'h55, 'h30},
                       '{'hAA, 'h55, 'h90,    0,    0,    0}};
  int seq_n    [4] = '{4, 6, 6, 3};
  int seq_busy [4] = '{PROG, ERASE, ERASE, 0};

  // Model state: accepted writes of the sequence in progress, busy time left, idle time.
  logic [10:0] m_ha [6];
  logic [7:0]  m_hd [6];
  int          m_len   = 0;
  int          m_busy  = 0;
  int          m_idle  = 0;
  logic        m_abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic step_match(int k, int i, logic [10:0] a, logic [7:0] d);
    return (seq_a[k][i] < 0 || seq_a[k][i] == int'(a)) &&
           (seq_d[k][i] < 0 || seq_d[k][i] == int'(d));
  endfunction

  // Is history + (a,d) a prefix of some legal sequence; kd = sequence it completes, else -1.
  function automatic logic prefix_ok(logic [10:0] a, logic [7:0] d, output int kd);
    logic ok = 1'b0;
    kd = -1;
    for (int k = 0; k < 4; k++) begin
      if (m_len < seq_n[k]) begin
        logic m = step_match(k, m_len, a, d);
        for (int i = 0; i < m_len; i++)
          if (!step_match(k, i, m_ha[i], m_hd[i])) m = 1'b0;
        if (m) begin
          ok = 1'b1;
          if (m_len + 1 == seq_n[k]) kd = k;
        end
      end
    end
    return ok;
  endfunction

  function automatic logic model_allow(output int kd);
    logic wr = !bus_if.romsel && !bus_if.cpu_rw_in;
    logic ok;
    kd = -1;
    if (rst || !wr || !bus_if.prg_write_enabled || m_busy > 0) return 1'b0;
    if (bus_if.cpu_data_in == 8'hF0) return 1'b1;
    ok = prefix_ok(bus_if.cpu_addr_in[10:0], bus_if.cpu_data_in, kd);
    return ok;
  endfunction

  function automatic int exp_state();
    if (m_busy > 0) return 7;
    case (m_len)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return (m_hd[2] == 8'hA0) ? 3 : 4;
      4: return 5;
      5: return 6;
      default: return 0;
    endcase
  endfunction

  // Reference model advance on each falling m2 edge (and on reset).
  initial forever begin
    int   kd;
    logic allow;
    logic wr;
    @(negedge m2 or posedge rst);
    if (rst) begin
      m_len = 0; m_busy = 0; m_idle = 0; m_abort = 1'b0;
    end else begin
      allow   = model_allow(kd);
      wr      = !bus_if.romsel && !bus_if.cpu_rw_in;
      m_abort = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (m_len > 0 && !bus_if.prg_write_enabled) begin
        m_len = 0; m_idle = 0; m_abort = 1'b1;
      end else if (wr) begin
        if (allow) begin
          m_idle = 0;
          if (bus_if.cpu_data_in == 8'hF0) begin
            m_len = 0;
          end else begin
            m_ha[m_len] = bus_if.cpu_addr_in[10:0];
            m_hd[m_len] = bus_if.cpu_data_in;
            m_len++;
            if (kd >= 0) begin
              m_busy = seq_busy[kd];
              m_len  = 0;
            end
          end
        end else if (m_len > 0) begin
          m_len = 0; m_idle = 0; m_abort = 1'b1;
        end
      end else if (m_len > 0) begin
        m_idle++;
        if (m_idle >= TMO) begin
          m_len = 0; m_idle = 0; m_abort = 1'b1;
        end
      end
    end
  end

  // Compare all outputs against the model every rising m2 edge.
  initial forever begin
    int kd;
    @(posedge m2);
    chk("cmp_write_allow", 32'(bus_if.write_allow), 32'(model_allow(kd)));
    chk("cmp_flash_busy",  32'(bus_if.flash_busy),  32'(m_busy > 0));
    chk("cmp_abort_pulse", 32'(bus_if.abort_pulse), 32'(m_abort));
    chk("cmp_seq_state",   32'(bus_if.seq_state),   32'(exp_state()));
  end

  task automatic bus_idle();
    bus_if.romsel      = 1'b1;
    bus_if.cpu_rw_in   = 1'b1;
    bus_if.cpu_addr_in = 15'h0;
    bus_if.cpu_data_in = 8'h00;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge m2);
      #1;
    end
  endtask

  task automatic read_cyc(input int n);
    bus_if.romsel    = 1'b0;
    bus_if.cpu_rw_in = 1'b1;
    idle_cyc(n);
    bus_idle();
  endtask

  // One CPU write cycle; checks the permit against a hand-computed value.
  task automatic cyc_write(input logic [15:0] addr, input logic [7:0] d,
                           input logic exp_allow, input string nm);
    bus_if.romsel      = ~addr[15];
    bus_if.cpu_rw_in   = 1'b0;
    bus_if.cpu_addr_in = addr[14:0];
    bus_if.cpu_data_in = d;
    @(posedge m2);
    chk(nm, 32'(bus_if.write_allow), 32'(exp_allow));
    @(negedge m2);
    #1;
    bus_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    bus_if.prg_write_enabled = 1'b1;
    bus_idle();
    #2 rst = 1'b1;
    // A legal $F0 write while reset is held must still be blocked.
    bus_if.romsel      = 1'b0;
    bus_if.cpu_rw_in   = 1'b0;
    bus_if.cpu_data_in = 8'hF0;
    @(posedge m2);
    chk("rst_write_allow", 32'(bus_if.write_allow), 32'd0);
    chk("rst_flash_busy",  32'(bus_if.flash_busy),  32'd0);
    chk("rst_abort",       32'(bus_if.abort_pulse), 32'd0);
    chk("rst_seq_state",   32'(bus_if.seq_state),   32'd0);
    @(negedge m2);
    #1;
    rst = 1'b0;
    bus_idle();
    idle_cyc(2);

    // Program: four writes allowed, then exactly PROG busy cycles with writes blocked.
    cyc_write(16'h8555, 8'hAA, 1'b1, "prog_w1");
    cyc_write(16'h82AA, 8'h55, 1'b1, "prog_w2");
    cyc_write(16'h8555, 8'hA0, 1'b1, "prog_w3");
    cyc_write(16'h9123, 8'h3C, 1'b1, "prog_w4");
    chk("prog_state_busy", 32'(bus_if.seq_state), 32'd7);
    n = 0;
    while (bus_if.flash_busy === 1'b1 && n < 200) begin
      cyc_write(16'h8555, 8'hAA, 1'b0, "prog_busy_block");
      n++;
    end
    chk("prog_busy_len", 32'(n), 32'd16);
    chk("prog_state_idle", 32'(bus_if.seq_state), 32'd0);

    // Chip erase: six writes allowed, then ERASE busy cycles.
    cyc_write(16'h8555, 8'hAA, 1'b1, "chip_w1");
    cyc_write(16'h82AA, 8'h55, 1'b1, "chip_w2");
    cyc_write(16'h8555, 8'h80, 1'b1, "chip_w3");
    cyc_write(16'h8555, 8'hAA, 1'b1, "chip_w4");
    cyc_write(16'h82AA, 8'h55, 1'b1, "chip_w5");
    cyc_write(16'h8555, 8'h10, 1'b1, "chip_w6");
    chk("chip_state_busy", 32'(bus_if.seq_state), 32'd7);
    n = 0;
    while (bus_if.flash_busy === 1'b1 && n < 300) begin
      idle_cyc(1);
      n++;
    end
    chk("chip_busy_len", 32'(n), 32'd100);
    chk("chip_state_idle", 32'(bus_if.seq_state), 32'd0);

    // Bad unlock: second write blocked, one-cycle abort pulse.
    cyc_write(16'h8555, 8'hAA, 1'b1, "bad_w1");
    cyc_write(16'h82AA, 8'h56, 1'b0, "bad_w2");
    chk("bad_abort", 32'(bus_if.abort_pulse), 32'd1);
    chk("bad_state", 32'(bus_if.seq_state), 32'd0);
    idle_cyc(1);
    chk("bad_abort_clear", 32'(bus_if.abort_pulse), 32'd0);

    // Timeout: abort after the 64th idle cycle; next unlock step blocked.
    cyc_write(16'h8555, 8'hAA, 1'b1, "tmo_w1");
    read_cyc(63);
    chk("tmo_63_abort", 32'(bus_if.abort_pulse), 32'd0);
    chk("tmo_63_state", 32'(bus_if.seq_state), 32'd1);
    read_cyc(1);
    chk("tmo_64_abort", 32'(bus_if.abort_pulse), 32'd1);
    chk("tmo_64_state", 32'(bus_if.seq_state), 32'd0);
    cyc_write(16'h82AA, 8'h55, 1'b0, "tmo_late_w2");

    // A write landing on the timeout edge wins.
    cyc_write(16'h8555, 8'hAA, 1'b1, "edge_w1");
    read_cyc(63);
    cyc_write(16'h82AA, 8'h55, 1'b1, "edge_w2");
    chk("edge_state", 32'(bus_if.seq_state), 32'd2);
    chk("edge_abort", 32'(bus_if.abort_pulse), 32'd0);
    cyc_write(16'h8000, 8'hF0, 1'b1, "edge_reset_cmd");
    chk("edge_reset_state", 32'(bus_if.seq_state), 32'd0);

    // Reset command mid-sequence and autoselect both return to IDLE quietly.
    cyc_write(16'h8555, 8'hAA, 1'b1, "f0_w1");
    cyc_write(16'h8123, 8'hF0, 1'b1, "f0_w2");
    chk("f0_state", 32'(bus_if.seq_state), 32'd0);
    chk("f0_abort", 32'(bus_if.abort_pulse), 32'd0);
    cyc_write(16'h8555, 8'hAA, 1'b1, "asel_w1");
    cyc_write(16'h82AA, 8'h55, 1'b1, "asel_w2");
    cyc_write(16'h8555, 8'h90, 1'b1, "asel_w3");
    chk("asel_state", 32'(bus_if.seq_state), 32'd0);
    chk("asel_busy", 32'(bus_if.flash_busy), 32'd0);

    // Permission off: everything blocked, IDLE kept, no abort.
    bus_if.prg_write_enabled = 1'b0;
    cyc_write(16'h8555, 8'hAA, 1'b0, "perm_w1");
    cyc_write(16'h82AA, 8'h55, 1'b0, "perm_w2");
    cyc_write(16'h8555, 8'hA0, 1'b0, "perm_w3");
    cyc_write(16'h9123, 8'h3C, 1'b0, "perm_w4");
    chk("perm_state", 32'(bus_if.seq_state), 32'd0);
    chk("perm_abort", 32'(bus_if.abort_pulse), 32'd0);
    // Permission dropped while in U2.
    bus_if.prg_write_enabled = 1'b1;
    cyc_write(16'h8555, 8'hAA, 1'b1, "drop_w1");
    cyc_write(16'h82AA, 8'h55, 1'b1, "drop_w2");
    bus_if.prg_write_enabled = 1'b0;
    idle_cyc(1);
    chk("drop_abort", 32'(bus_if.abort_pulse), 32'd1);
    chk("drop_state", 32'(bus_if.seq_state), 32'd0);
    bus_if.prg_write_enabled = 1'b1;
    idle_cyc(1);

    // Reset during a sector erase clears busy at once.
    cyc_write(16'h8555, 8'hAA, 1'b1, "sect_w1");
    cyc_write(16'h82AA, 8'h55, 1'b1, "sect_w2");
    cyc_write(16'h8555, 8'h80, 1'b1, "sect_w3");
    cyc_write(16'h8555, 8'hAA, 1'b1, "sect_w4");
    cyc_write(16'h82AA, 8'h55, 1'b1, "sect_w5");
    cyc_write(16'h9ABC, 8'h30, 1'b1, "sect_w6");
    idle_cyc(5);
    chk("sect_busy", 32'(bus_if.flash_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus_if.flash_busy), 32'd0);
    chk("midrst_state", 32'(bus_if.seq_state), 32'd0);
    @(negedge m2);
    #1;
    rst = 1'b0;
    cyc_write(16'h8000, 8'hF0, 1'b1, "post_rst_f0");
    idle_cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
